// File: rtl/sdrc_xfr_responder.sv
`default_nettype none
// ============================================================================
// Module   : sdrc_xfr_responder
// Purpose  : Responder end of the bank-FSM -> transfer handshake. Accepts
//            PRE/ACT/RD/WR requests, acks them combinationally, issues
//            registered SDRAM commands, runs single-beat RD/WR bursts with
//            column stepping, reports per-bank readiness and (optionally)
//            owns the auto-refresh sequence.
// Config   : SDRC_AUTO_RFSH_EN - when defined, adds the refresh interval
//            timer and the PRE-all / REFRESH sequence. When undefined the
//            refresh logic is absent and x2b_refresh is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module sdrc_xfr_responder #(
  parameter int BANK_ID = 0,
  parameter int LEN_W   = 12,
  parameter int CL_MAX  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             b2x_req,
  input  logic [1:0]       b2x_cmd,
  input  logic [12:0]      b2x_addr,
  input  logic [LEN_W-1:0] b2x_len,
  input  logic             b2x_wrap,
  input  logic [3:0]       b2x_id,
  output logic             x2b_ack,
  output logic             x2b_pre_ok,
  output logic             x2b_act_ok,
  output logic             x2b_rdok,
  output logic             x2b_wrok,
  output logic             xfr_ok,
  output logic             x2b_refresh,
  input  logic [3:0]       twr_delay,
  input  logic [3:0]       trrd_delay,
  input  logic [3:0]       trp_delay,
  input  logic [3:0]       trc_delay,
  input  logic [1:0]       cas_latency,
  input  logic [11:0]      rfsh_time,
  output logic [3:0]       sdr_cmd,
  output logic [12:0]      sdr_addr,
  output logic [1:0]       sdr_ba,
  output logic             x2a_wrnext,
  output logic             x2a_rdvalid,
  output logic [3:0]       x2a_id
);

  // SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] c_cmd_desel = 4'b1111;
  localparam logic [3:0] c_cmd_noop  = 4'b0111;
  localparam logic [3:0] c_cmd_act   = 4'b0011;
  localparam logic [3:0] c_cmd_rd    = 4'b0101;
  localparam logic [3:0] c_cmd_wr    = 4'b0100;
  localparam logic [3:0] c_cmd_pre   = 4'b0010;
  localparam logic [3:0] c_cmd_ref   = 4'b0001;

  // Request encodings on b2x_cmd
  localparam logic [1:0] c_req_pre = 2'b00;
  localparam logic [1:0] c_req_act = 2'b01;
  localparam logic [1:0] c_req_rd  = 2'b10;
  localparam logic [1:0] c_req_wr  = 2'b11;

  localparam logic [1:0] c_bank = BANK_ID[1:0];

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_XFR    = 3'd1,
    ST_RF_PRE = 3'd2,
    ST_RF_TRP = 3'd3,
    ST_RF_CMD = 3'd4,
    ST_RF_TRC = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;

  logic [3:0]       r_cmd, w_cmd_nxt;
  logic [12:0]      r_addr, w_addr_nxt;
  logic [12:0]      r_col, w_col_nxt;
  logic [LEN_W-1:0] r_left, w_left_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic             r_is_wr, w_is_wr_nxt;
  logic [3:0]       r_xfr_id, w_xfr_id_nxt;
  logic             r_wrnext, w_wrnext_nxt;

  logic [3:0]       r_twr_cnt, r_trrd_cnt;
  logic             w_twr_load, w_trrd_load;

  logic [CL_MAX:1]  r_rd_sr;
  logic [3:0]       r_rd_id [1:CL_MAX];
  logic [1:0]       w_cl;
  logic             w_rdvalid;
  logic [3:0]       w_rd_id;

  logic             w_rfsh_pend;
  logic             w_cmd_ok;
  logic             w_idle_ok;

`ifdef SDRC_AUTO_RFSH_EN
  logic [11:0]      r_rfsh_cnt;
  logic             r_rfsh_pend;
  logic [3:0]       r_wait;
  logic             w_wait_load;
  logic [3:0]       w_wait_val;
  logic             w_rfsh_done;
  logic             r_refresh, w_refresh_nxt;

  // Expiry counts as pending in the same cycle so a simultaneous request loses.
  assign w_rfsh_pend = r_rfsh_pend | (r_rfsh_cnt == 12'd1);
  assign x2b_refresh = r_refresh;
`else
  logic             w_unused_cfg;

  assign w_unused_cfg = ^{rfsh_time, trp_delay, trc_delay};
  assign w_rfsh_pend  = 1'b0;
  assign x2b_refresh  = 1'b0;
`endif

  // Column stepping: wrap keeps the aligned 8-word block, otherwise linear.
  function automatic logic [12:0] f_next_col(input logic [12:0] col, input logic wrap);
    if (wrap) begin
      return {col[12:3], col[2:0] + 3'd1};
    end
    return col + 13'd1;
  endfunction

  // RD/WR never use auto-precharge, so A10 is always driven low.
  function automatic logic [12:0] f_no_ap(input logic [12:0] a);
    return {a[12:11], 1'b0, a[9:0]};
  endfunction

  // Readiness flags; all held low while reset is asserted.
  assign w_idle_ok  = ~reset & (r_state == ST_IDLE) & ~w_rfsh_pend;
  assign x2b_pre_ok = ~reset & (r_twr_cnt == 4'd0);
  assign x2b_act_ok = ~reset & (r_trrd_cnt == 4'd0) & ~w_rfsh_pend;
  assign x2b_rdok   = w_idle_ok;
  assign x2b_wrok   = w_idle_ok;
  assign xfr_ok     = w_idle_ok;

  // Per-command permission for the incoming request.
  always_comb begin
    w_cmd_ok = 1'b0;
    case (b2x_cmd)
      c_req_pre: w_cmd_ok = x2b_pre_ok;
      c_req_act: w_cmd_ok = x2b_act_ok;
      c_req_rd:  w_cmd_ok = x2b_rdok;
      c_req_wr:  w_cmd_ok = x2b_wrok;
      default:   w_cmd_ok = 1'b0;
    endcase
  end

  assign x2b_ack = b2x_req & (r_state == ST_IDLE) & ~w_rfsh_pend & w_cmd_ok;

  assign sdr_cmd    = r_cmd;
  assign sdr_addr   = r_addr;
  assign sdr_ba     = c_bank;
  assign x2a_wrnext = r_wrnext;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-command decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_nxt    = c_cmd_noop;
    w_addr_nxt   = r_addr;
    w_col_nxt    = r_col;
    w_left_nxt   = r_left;
    w_wrap_nxt   = r_wrap;
    w_is_wr_nxt  = r_is_wr;
    w_xfr_id_nxt = r_xfr_id;
    w_wrnext_nxt = 1'b0;
    w_twr_load   = 1'b0;
    w_trrd_load  = 1'b0;
`ifdef SDRC_AUTO_RFSH_EN
    w_wait_load   = 1'b0;
    w_wait_val    = 4'd0;
    w_rfsh_done   = 1'b0;
    w_refresh_nxt = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (x2b_ack) begin
          case (b2x_cmd)
            c_req_pre: begin
              w_cmd_nxt  = c_cmd_pre;
              w_addr_nxt = f_no_ap(b2x_addr);
            end
            c_req_act: begin
              w_cmd_nxt   = c_cmd_act;
              w_addr_nxt  = b2x_addr;
              w_trrd_load = 1'b1;
            end
            default: begin
              // RD or WR: first beat goes out now, the rest from ST_XFR.
              w_cmd_nxt    = (b2x_cmd == c_req_wr) ? c_cmd_wr : c_cmd_rd;
              w_addr_nxt   = f_no_ap(b2x_addr);
              w_col_nxt    = f_next_col(b2x_addr, b2x_wrap);
              w_left_nxt   = (b2x_len == '0) ? '0 : b2x_len - LEN_W'(1);
              w_wrap_nxt   = b2x_wrap;
              w_is_wr_nxt  = (b2x_cmd == c_req_wr);
              w_xfr_id_nxt = b2x_id;
              w_wrnext_nxt = (b2x_cmd == c_req_wr);
              w_state_nxt  = ST_XFR;
            end
          endcase
        end
`ifdef SDRC_AUTO_RFSH_EN
        else if (w_rfsh_pend && (r_twr_cnt == 4'd0)) begin
          w_cmd_nxt   = c_cmd_pre;
          w_addr_nxt  = 13'h0400;
          w_state_nxt = ST_RF_PRE;
        end
`endif
      end
      ST_XFR: begin
        if (r_left == '0) begin
          // Last beat is on the bus this cycle.
          w_state_nxt = ST_IDLE;
          w_twr_load  = r_is_wr;
        end else begin
          w_cmd_nxt    = r_is_wr ? c_cmd_wr : c_cmd_rd;
          w_addr_nxt   = f_no_ap(r_col);
          w_col_nxt    = f_next_col(r_col, r_wrap);
          w_left_nxt   = r_left - LEN_W'(1);
          w_wrnext_nxt = r_is_wr;
        end
      end
`ifdef SDRC_AUTO_RFSH_EN
      ST_RF_PRE: begin
        w_wait_load = 1'b1;
        w_wait_val  = trp_delay;
        w_state_nxt = ST_RF_TRP;
      end
      ST_RF_TRP: begin
        if (r_wait == 4'd0) begin
          w_cmd_nxt     = c_cmd_ref;
          w_refresh_nxt = 1'b1;
          w_state_nxt   = ST_RF_CMD;
        end
      end
      ST_RF_CMD: begin
        w_wait_load = 1'b1;
        w_wait_val  = trc_delay;
        w_state_nxt = ST_RF_TRC;
      end
      ST_RF_TRC: begin
        if (r_wait == 4'd0) begin
          w_rfsh_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command/address outputs and burst bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd    <= c_cmd_desel;
      r_addr   <= 13'd0;
      r_col    <= 13'd0;
      r_left   <= '0;
      r_wrap   <= 1'b0;
      r_is_wr  <= 1'b0;
      r_xfr_id <= 4'd0;
      r_wrnext <= 1'b0;
    end else begin
      r_cmd    <= w_cmd_nxt;
      r_addr   <= w_addr_nxt;
      r_col    <= w_col_nxt;
      r_left   <= w_left_nxt;
      r_wrap   <= w_wrap_nxt;
      r_is_wr  <= w_is_wr_nxt;
      r_xfr_id <= w_xfr_id_nxt;
      r_wrnext <= w_wrnext_nxt;
    end
  end

  // tWR and tRRD timers: load on event, count down and hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_twr_cnt  <= 4'd0;
      r_trrd_cnt <= 4'd0;
    end else begin
      if (w_twr_load) begin
        r_twr_cnt <= twr_delay;
      end else if (r_twr_cnt != 4'd0) begin
        r_twr_cnt <= r_twr_cnt - 4'd1;
      end
      if (w_trrd_load) begin
        r_trrd_cnt <= trrd_delay;
      end else if (r_trrd_cnt != 4'd0) begin
        r_trrd_cnt <= r_trrd_cnt - 4'd1;
      end
    end
  end

  // Read-valid delay line: each RD on the bus emerges cas_latency cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_sr <= '0;
      for (int k = 1; k <= CL_MAX; k++) begin
        r_rd_id[k] <= 4'd0;
      end
    end else begin
      r_rd_sr[1] <= (r_cmd == c_cmd_rd);
      r_rd_id[1] <= r_xfr_id;
      for (int k = 2; k <= CL_MAX; k++) begin
        r_rd_sr[k] <= r_rd_sr[k-1];
        r_rd_id[k] <= r_rd_id[k-1];
      end
    end
  end

  // A latency of 0 is treated as 1; anything above CL_MAX uses the last tap.
  assign w_cl = (cas_latency == 2'd0) ? 2'd1 : cas_latency;

  // Tap select for the read-valid delay line.
  always_comb begin
    w_rdvalid = 1'b0;
    w_rd_id   = 4'd0;
    for (int k = 1; k <= CL_MAX; k++) begin
      if ((k == int'(w_cl)) || ((k == CL_MAX) && (int'(w_cl) > CL_MAX))) begin
        w_rdvalid = r_rd_sr[k];
        w_rd_id   = r_rd_id[k];
      end
    end
  end

  assign x2a_rdvalid = w_rdvalid;
  assign x2a_id      = w_rdvalid ? w_rd_id : r_xfr_id;

`ifdef SDRC_AUTO_RFSH_EN
  // Refresh interval timer and pending flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rfsh_cnt  <= 12'd0;
      r_rfsh_pend <= 1'b0;
    end else if (w_rfsh_done) begin
      r_rfsh_pend <= 1'b0;
      r_rfsh_cnt  <= rfsh_time;
    end else if (r_rfsh_cnt == 12'd1) begin
      r_rfsh_cnt  <= 12'd0;
      r_rfsh_pend <= 1'b1;
    end else if ((r_rfsh_cnt == 12'd0) && !r_rfsh_pend) begin
      r_rfsh_cnt  <= rfsh_time;
    end else if (r_rfsh_cnt != 12'd0) begin
      r_rfsh_cnt  <= r_rfsh_cnt - 12'd1;
    end
  end

  // tRP/tRC wait counter and REFRESH notice pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait    <= 4'd0;
      r_refresh <= 1'b0;
    end else begin
      r_refresh <= w_refresh_nxt;
      if (w_wait_load) begin
        r_wait <= w_wait_val;
      end else if (r_wait != 4'd0) begin
        r_wait <= r_wait - 4'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdrc_xfr_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdrc_xfr_responder
// Purpose  : Scoreboard bench for sdrc_xfr_responder. Stimulus pushes the
//            expected SDRAM commands, write-beat IDs and read-return IDs;
//            a negedge monitor pops and compares whenever the DUT presents
//            a command, a write-next pulse or a read-valid beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdrc_xfr_responder;

  localparam logic [1:0] B_PRE = 2'b00;
  localparam logic [1:0] B_ACT = 2'b01;
  localparam logic [1:0] B_RD  = 2'b10;
  localparam logic [1:0] B_WR  = 2'b11;

  localparam logic [3:0] K_ACT = 4'b0011;
  localparam logic [3:0] K_RD  = 4'b0101;
  localparam logic [3:0] K_WR  = 4'b0100;
  localparam logic [3:0] K_PRE = 4'b0010;
  localparam logic [3:0] K_REF = 4'b0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        b2x_req;
  logic [1:0]  b2x_cmd;
  logic [12:0] b2x_addr;
  logic [11:0] b2x_len;
  logic        b2x_wrap;
  logic [3:0]  b2x_id;
  logic        x2b_ack, x2b_pre_ok, x2b_act_ok, x2b_rdok, x2b_wrok, xfr_ok, x2b_refresh;
  logic [3:0]  twr_delay, trrd_delay, trp_delay, trc_delay;
  logic [1:0]  cas_latency;
  logic [11:0] rfsh_time;
  logic [3:0]  sdr_cmd;
  logic [12:0] sdr_addr;
  logic [1:0]  sdr_ba;
  logic        x2a_wrnext, x2a_rdvalid;
  logic [3:0]  x2a_id;

  sdrc_xfr_responder #(.BANK_ID(0), .LEN_W(12), .CL_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .b2x_req(b2x_req), .b2x_cmd(b2x_cmd), .b2x_addr(b2x_addr), .b2x_len(b2x_len),
    .b2x_wrap(b2x_wrap), .b2x_id(b2x_id),
    .x2b_ack(x2b_ack), .x2b_pre_ok(x2b_pre_ok), .x2b_act_ok(x2b_act_ok),
    .x2b_rdok(x2b_rdok), .x2b_wrok(x2b_wrok), .xfr_ok(xfr_ok), .x2b_refresh(x2b_refresh),
    .twr_delay(twr_delay), .trrd_delay(trrd_delay), .trp_delay(trp_delay),
    .trc_delay(trc_delay), .cas_latency(cas_latency), .rfsh_time(rfsh_time),
    .sdr_cmd(sdr_cmd), .sdr_addr(sdr_addr), .sdr_ba(sdr_ba),
    .x2a_wrnext(x2a_wrnext), .x2a_rdvalid(x2a_rdvalid), .x2a_id(x2a_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        chk_addr;
  } exp_t;

  exp_t       exp_cmd [$];
  logic [3:0] exp_wr_id [$];
  logic [3:0] exp_rd_id [$];
  logic       rfsh_allow = 1'b0;
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;

  task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event, value 0x%0h, expected none", name, act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [12:0] a, input logic [11:0] l,
                       input logic w, input logic [3:0] id);
    b2x_req  = 1'b1;
    b2x_cmd  = c;
    b2x_addr = a;
    b2x_len  = l;
    b2x_wrap = w;
    b2x_id   = id;
  endtask

  task automatic push_cmd(input logic [3:0] c, input logic [12:0] a, input logic chk);
    exp_t e;
    e.cmd = c;
    e.addr = a;
    e.chk_addr = chk;
    exp_cmd.push_back(e);
  endtask

  // Monitor: compare every non-idle command, write pulse and read return.
  always @(negedge clk) begin
    if ((sdr_cmd !== 4'b1111) && (sdr_cmd !== 4'b0111) && (sdr_cmd !== 4'bxxxx)) begin
      if (exp_cmd.size() == 0) begin
        unexpected("sdr_cmd", 32'(sdr_cmd));
      end else begin
        mon_e = exp_cmd.pop_front();
        check_v("sdr_cmd", 32'(sdr_cmd), 32'(mon_e.cmd));
        if (mon_e.chk_addr) check_v("sdr_addr", 32'(sdr_addr), 32'(mon_e.addr));
        check_v("sdr_ba", 32'(sdr_ba), 32'd0);
      end
    end
    if (x2a_wrnext === 1'b1) begin
      if (exp_wr_id.size() == 0) unexpected("x2a_wrnext", 32'(x2a_id));
      else check_v("wr_id", 32'(x2a_id), 32'(exp_wr_id.pop_front()));
    end
    if (x2a_rdvalid === 1'b1) begin
      if (exp_rd_id.size() == 0) unexpected("x2a_rdvalid", 32'(x2a_id));
      else check_v("rd_id", 32'(x2a_id), 32'(exp_rd_id.pop_front()));
    end
    if ((x2b_refresh === 1'b1) && !rfsh_allow) unexpected("x2b_refresh", 32'd1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal;
  end

  initial begin
    int rv_cnt;
    reset = 1'b1;
    drive(B_ACT, 13'h001, 12'd0, 1'b0, 4'd0);
    twr_delay = 4'd3; trrd_delay = 4'd2; trp_delay = 4'd2; trc_delay = 4'd2;
    cas_latency = 2'd2; rfsh_time = 12'd0;

    // Reset: DESEL, no ack even with a request pending.
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check_v("rst_cmd", 32'(sdr_cmd), 32'hF);
      check_b("rst_ack", x2b_ack, 1'b0);
    end
    check_b("rst_act_ok", x2b_act_ok, 1'b0);
    check_b("rst_wrnext", x2a_wrnext, 1'b0);
    check_b("rst_rdvalid", x2a_rdvalid, 1'b0);
    step();
    reset = 1'b0;
    b2x_req = 1'b0;
    @(negedge clk);
    check_b("rel_pre_ok", x2b_pre_ok, 1'b1);
    check_b("rel_act_ok", x2b_act_ok, 1'b1);
    check_b("rel_rdok", x2b_rdok, 1'b1);
    check_b("rel_wrok", x2b_wrok, 1'b1);

    // ACT 0x123 then a second ACT held off by tRRD=2.
    for (int i = 0; i < 4; i++) begin
      step();
      drive(B_ACT, (i == 0) ? 13'h123 : 13'h055, 12'd0, 1'b0, 4'd0);
      @(negedge clk);
      check_b("act_ack", x2b_ack, (i == 0) || (i == 3));
      if (i == 1) check_b("act_ok_trrd", x2b_act_ok, 1'b0);
      if (i == 0) push_cmd(K_ACT, 13'h123, 1'b1);
      if (i == 3) push_cmd(K_ACT, 13'h055, 1'b1);
    end
    step();
    b2x_req = 1'b0;
    step();

    // Wrapped WR burst, then PRE held off during burst and for tWR=3.
    step();
    drive(B_WR, 13'h006, 12'd4, 1'b1, 4'd5);
    @(negedge clk);
    check_b("wr_ack", x2b_ack, 1'b1);
    push_cmd(K_WR, 13'h006, 1'b1);
    push_cmd(K_WR, 13'h007, 1'b1);
    push_cmd(K_WR, 13'h000, 1'b1);
    push_cmd(K_WR, 13'h001, 1'b1);
    for (int i = 0; i < 4; i++) exp_wr_id.push_back(4'd5);
    for (int i = 1; i <= 8; i++) begin
      step();
      drive(B_PRE, 13'h5FF, 12'd0, 1'b0, 4'd0);
      @(negedge clk);
      if (i == 1) begin
        check_b("wr_xfr_ok", xfr_ok, 1'b0);
        check_b("wr_wrok", x2b_wrok, 1'b0);
      end
      if (i == 5) check_b("twr_pre_ok", x2b_pre_ok, 1'b0);
      check_b("pre_ack", x2b_ack, i == 8);
      if (i == 8) push_cmd(K_PRE, 13'h1FF, 1'b1);
    end
    step();
    b2x_req = 1'b0;

    // Linear WR crossing an 8-word boundary.
    step();
    drive(B_WR, 13'h00E, 12'd3, 1'b0, 4'd6);
    @(negedge clk);
    check_b("wr2_ack", x2b_ack, 1'b1);
    push_cmd(K_WR, 13'h00E, 1'b1);
    push_cmd(K_WR, 13'h00F, 1'b1);
    push_cmd(K_WR, 13'h010, 1'b1);
    for (int i = 0; i < 3; i++) exp_wr_id.push_back(4'd6);
    step();
    b2x_req = 1'b0;
    repeat (5) step();

    // RD burst of 2 with CL=2.
    drive(B_RD, 13'h010, 12'd2, 1'b0, 4'd9);
    @(negedge clk);
    check_b("rd_ack", x2b_ack, 1'b1);
    push_cmd(K_RD, 13'h010, 1'b1);
    push_cmd(K_RD, 13'h011, 1'b1);
    exp_rd_id.push_back(4'd9);
    exp_rd_id.push_back(4'd9);
    step();
    b2x_req = 1'b0;
    @(negedge clk);
    check_b("rd_xfr_ok", xfr_ok, 1'b0);
    check_b("rd_rdok", x2b_rdok, 1'b0);
    check_b("rd_valid_d1", x2a_rdvalid, 1'b0);
    step();
    @(negedge clk);
    check_b("rd_valid_d2", x2a_rdvalid, 1'b0);
    step();
    @(negedge clk);
    check_b("rd_valid_d3", x2a_rdvalid, 1'b1);
    step();
    @(negedge clk);
    check_b("rd_valid_d4", x2a_rdvalid, 1'b1);
    step();
    @(negedge clk);
    check_b("rd_valid_d5", x2a_rdvalid, 1'b0);
    check_b("rd_xfr_ok_end", xfr_ok, 1'b1);

    // len 0 means one beat; A10 forced low on the column.
    step();
    drive(B_RD, 13'h7FF, 12'd0, 1'b0, 4'd2);
    @(negedge clk);
    check_b("rd1_ack", x2b_ack, 1'b1);
    push_cmd(K_RD, 13'h3FF, 1'b1);
    exp_rd_id.push_back(4'd2);
    step();
    b2x_req = 1'b0;
    repeat (5) step();

    // Reset in the middle of an 8-beat read.
    drive(B_RD, 13'h020, 12'd8, 1'b0, 4'd3);
    @(negedge clk);
    check_b("abort_ack", x2b_ack, 1'b1);
    push_cmd(K_RD, 13'h020, 1'b1);
    push_cmd(K_RD, 13'h021, 1'b1);
    step();
    b2x_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check_v("abort_cmd", 32'(sdr_cmd), 32'hF);
    rv_cnt = 0;
    if (x2a_rdvalid === 1'b1) rv_cnt++;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (x2a_rdvalid === 1'b1) rv_cnt++;
      step();
    end
    check_v("abort_rdvalid_cnt", 32'(rv_cnt), 32'd0);
    check_b("abort_xfr_ok", xfr_ok, 1'b1);

`ifdef SDRC_AUTO_RFSH_EN
    // Refresh expiry coincides with a request: refresh wins.
    reset = 1'b1;
    rfsh_time = 12'd50;
    step();
    step();
    reset = 1'b0;
    for (int k = 1; k <= 50; k++) step();
    drive(B_ACT, 13'h001, 12'd0, 1'b0, 4'd0);
    @(negedge clk);
    check_b("rfsh_req_ack", x2b_ack, 1'b0);
    push_cmd(K_PRE, 13'h0400, 1'b1);
    push_cmd(K_REF, 13'h0000, 1'b0);
    rfsh_allow = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      step();
      @(negedge clk);
      check_b("rfsh_pulse", x2b_refresh, j == 5);
      check_b("rfsh_ack", x2b_ack, j == 9);
      if (j == 9) push_cmd(K_ACT, 13'h001, 1'b1);
    end
    rfsh_allow = 1'b0;
    step();
    b2x_req = 1'b0;
`endif

    repeat (6) step();
    check_v("cmd_queue_left", 32'(exp_cmd.size()), 32'd0);
    check_v("wr_queue_left", 32'(exp_wr_id.size()), 32'd0);
    check_v("rd_queue_left", 32'(exp_rd_id.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
